// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: load-use stall, mispredict squash and memory-wait freeze for IF/ID and ID/EX latches.
// Control outputs are same-cycle combinational; state, remaining-cycle count and perf counters are registered.
module hazard_ctrl #(
   parameter int unsigned LOAD_LAT    = 1,
   parameter int unsigned FLUSH_EXTRA = 0,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             stg_clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_rd_memory,
   input  logic             ex_save_to_reg,
   input  logic             ex_branch_resolve,
   input  logic             ex_mispredict,
   input  logic             mem_busy,
   output logic             pc_hold,
   output logic             fetch_stg_ena,
   output logic             fetch_stg_x,
   output logic             decode_stg_ena,
   output logic             decode_stg_x,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      FLUSH    = 2'd2
   } state_e;

   // rem only ever holds the longer of the two multi-cycle windows
   localparam int unsigned REM_MAX = (LOAD_LAT - 1 > FLUSH_EXTRA) ? LOAD_LAT - 1 : FLUSH_EXTRA;
   localparam int unsigned REM_W   = (REM_MAX < 2) ? 1 : $clog2(REM_MAX + 1);

   state_e             state_q, state_d;
   logic [REM_W-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
   logic               stall_inc, flush_inc;
   logic               hz, mp;

   assign hz = ex_valid & ex_rd_memory & ex_save_to_reg & (ex_rd != 5'd0) & id_valid &
               ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
   assign mp = ex_branch_resolve & ex_mispredict;

   always_comb begin
      state_d        = state_q;
      rem_d          = rem_q;
      pc_hold        = 1'b0;
      fetch_stg_ena  = 1'b0;
      fetch_stg_x    = 1'b0;
      decode_stg_ena = 1'b0;
      decode_stg_x   = 1'b0;
      stall_inc      = 1'b0;
      flush_inc      = 1'b0;
      if (!reset) begin
         if (mem_busy) begin
            pc_hold        = 1'b1;
            fetch_stg_ena  = 1'b1;
            decode_stg_ena = 1'b1;
            stall_inc      = 1'b1;
         end else if (mp) begin
            fetch_stg_x  = 1'b1;
            decode_stg_x = 1'b1;
            flush_inc    = 1'b1;
            if (FLUSH_EXTRA == 0) begin
               state_d = RUN;
            end else begin
               state_d = FLUSH;
               rem_d   = REM_W'(FLUSH_EXTRA);
            end
         end else begin
            case (state_q)
               FLUSH: begin
                  fetch_stg_x  = 1'b1;
                  decode_stg_x = 1'b1;
                  flush_inc    = 1'b1;
                  rem_d        = rem_q - REM_W'(1);
                  if (rem_q <= REM_W'(1)) state_d = RUN;
               end
               LD_STALL: begin
                  pc_hold       = 1'b1;
                  fetch_stg_ena = 1'b1;
                  decode_stg_x  = 1'b1;
                  stall_inc     = 1'b1;
                  rem_d         = rem_q - REM_W'(1);
                  if (rem_q <= REM_W'(1)) state_d = RUN;
               end
               default: begin
                  if (hz) begin
                     pc_hold       = 1'b1;
                     fetch_stg_ena = 1'b1;
                     decode_stg_x  = 1'b1;
                     stall_inc     = 1'b1;
                     if (LOAD_LAT <= 1) begin
                        state_d = RUN;
                     end else begin
                        state_d = LD_STALL;
                        rem_d   = REM_W'(LOAD_LAT - 1);
                     end
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge stg_clk) begin
      if (reset) begin
         state_q     <= RUN;
         rem_q       <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         // saturate rather than wrap so long runs stay meaningful
         if (stall_inc && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (flush_inc && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
   end

   assign state     = state_q;
   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT=3/FLUSH_EXTRA=2/CNT_W=4 and LOAD_LAT=1/FLUSH_EXTRA=0/CNT_W=32)
// driven in lockstep and compared against a cycle-count reference model.
module tb_hazard_ctrl;

   logic clk;
   logic reset, id_valid, id_rs1_used, id_rs2_used, ex_valid, ex_rd_memory, ex_save_to_reg;
   logic ex_branch_resolve, ex_mispredict, mem_busy;
   logic [4:0] id_rs1, id_rs2, ex_rd;

   logic ph0, fe0, fx0, de0, dx0, ph1, fe1, fx1, de1, dx1;
   logic [1:0] st0, st1;
   logic [3:0] sc0, fc0;
   logic [31:0] sc1, fc1;

   hazard_ctrl #(.LOAD_LAT(3), .FLUSH_EXTRA(2), .CNT_W(4)) dut0 (
      .stg_clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_rd_memory(ex_rd_memory), .ex_save_to_reg(ex_save_to_reg),
      .ex_branch_resolve(ex_branch_resolve), .ex_mispredict(ex_mispredict), .mem_busy(mem_busy),
      .pc_hold(ph0), .fetch_stg_ena(fe0), .fetch_stg_x(fx0), .decode_stg_ena(de0),
      .decode_stg_x(dx0), .state(st0), .stall_cnt(sc0), .flush_cnt(fc0));

   hazard_ctrl #(.LOAD_LAT(1), .FLUSH_EXTRA(0), .CNT_W(32)) dut1 (
      .stg_clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_valid(ex_valid), .ex_rd(ex_rd),
      .ex_rd_memory(ex_rd_memory), .ex_save_to_reg(ex_save_to_reg),
      .ex_branch_resolve(ex_branch_resolve), .ex_mispredict(ex_mispredict), .mem_busy(mem_busy),
      .pc_hold(ph1), .fetch_stg_ena(fe1), .fetch_stg_x(fx1), .decode_stg_ena(de1),
      .decode_stg_x(dx1), .state(st1), .stall_cnt(sc1), .flush_cnt(fc1));

   // control vector order: {pc_hold, fetch_ena, fetch_x, decode_ena, decode_x}
   logic [4:0] g_ctrl [2];
   logic [1:0] g_st [2];
   longint unsigned g_sc [2], g_fc [2];
   assign g_ctrl[0] = {ph0, fe0, fx0, de0, dx0};
   assign g_ctrl[1] = {ph1, fe1, fx1, de1, dx1};
   assign g_st[0] = st0;
   assign g_st[1] = st1;
   assign g_sc[0] = 64'(sc0);
   assign g_sc[1] = 64'(sc1);
   assign g_fc[0] = 64'(fc0);
   assign g_fc[1] = 64'(fc1);

   localparam logic [4:0] C_IDLE  = 5'b00000;
   localparam logic [4:0] C_BUSY  = 5'b11010;
   localparam logic [4:0] C_STALL = 5'b11001;
   localparam logic [4:0] C_SQ    = 5'b00101;

   int n_chk = 0;
   int n_pass = 0;

   // reference model: cycles of squash / load stall still owed, plus saturating counts
   int              LL [2]   = '{3, 1};
   int              FE [2]   = '{2, 0};
   longint unsigned MAXC [2] = '{64'd15, 64'hFFFF_FFFF};
   int              m_ld [2] = '{0, 0};
   int              m_fl [2] = '{0, 0};
   longint unsigned m_sc [2] = '{0, 0};
   longint unsigned m_fc [2] = '{0, 0};
   int              n_ld [2], n_fl [2];
   longint unsigned n_sc [2], n_fc [2];
   logic [4:0]      e_ctrl [2];
   logic [1:0]      e_st [2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit ref_hz();
      bit src1, src2;
      src1 = id_rs1_used && (id_rs1 == ex_rd);
      src2 = id_rs2_used && (id_rs2 == ex_rd);
      return ex_valid && ex_rd_memory && ex_save_to_reg && (ex_rd != 0) && id_valid && (src1 || src2);
   endfunction

   task automatic model_eval();
      for (int k = 0; k < 2; k++) begin
         e_st[k] = (m_fl[k] > 0) ? 2'd2 : ((m_ld[k] > 0) ? 2'd1 : 2'd0);
         n_ld[k] = m_ld[k]; n_fl[k] = m_fl[k]; n_sc[k] = m_sc[k]; n_fc[k] = m_fc[k];
         e_ctrl[k] = C_IDLE;
         if (reset) begin
            n_ld[k] = 0; n_fl[k] = 0; n_sc[k] = 0; n_fc[k] = 0;
         end else if (mem_busy) begin
            e_ctrl[k] = C_BUSY;
            if (m_sc[k] < MAXC[k]) n_sc[k] = m_sc[k] + 1;
         end else if (ex_branch_resolve && ex_mispredict) begin
            e_ctrl[k] = C_SQ;
            if (m_fc[k] < MAXC[k]) n_fc[k] = m_fc[k] + 1;
            n_fl[k] = FE[k]; n_ld[k] = 0;
         end else if (m_fl[k] > 0) begin
            e_ctrl[k] = C_SQ;
            if (m_fc[k] < MAXC[k]) n_fc[k] = m_fc[k] + 1;
            n_fl[k] = m_fl[k] - 1;
         end else if (m_ld[k] > 0) begin
            e_ctrl[k] = C_STALL;
            if (m_sc[k] < MAXC[k]) n_sc[k] = m_sc[k] + 1;
            n_ld[k] = m_ld[k] - 1;
         end else if (ref_hz()) begin
            e_ctrl[k] = C_STALL;
            if (m_sc[k] < MAXC[k]) n_sc[k] = m_sc[k] + 1;
            n_ld[k] = LL[k] - 1;
         end
      end
   endtask

   // settle: sample at the falling edge with inputs stable; advance: commit model and clock
   task automatic settle();
      @(negedge clk);
      model_eval();
   endtask

   task automatic advance();
      for (int k = 0; k < 2; k++) begin
         m_ld[k] = n_ld[k]; m_fl[k] = n_fl[k]; m_sc[k] = n_sc[k]; m_fc[k] = n_fc[k];
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
      ex_valid = 0; ex_rd = 0; ex_rd_memory = 0; ex_save_to_reg = 0;
      ex_branch_resolve = 0; ex_mispredict = 0; mem_busy = 0;
   endtask

   task automatic do_reset();
      reset = 1;
      settle();
      advance();
      reset = 0;
      clear_inputs();
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic use1);
      ex_valid = 1; ex_rd_memory = 1; ex_save_to_reg = 1; ex_rd = rd;
      id_valid = 1; id_rs1 = 5'd5; id_rs1_used = use1; id_rs2 = 5'd5; id_rs2_used = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1; ex_branch_resolve = 1; ex_mispredict = 1; set_load_use(5'd5, 1'b1);
      settle();
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (g_ctrl[k] !== C_IDLE) $display("FAIL rst_ctrl%0d got %b want %b", k, g_ctrl[k], C_IDLE); else n_pass++;
      end
      advance();
      reset = 0; clear_inputs();
      settle();
      for (int k = 0; k < 2; k++) begin
         n_chk++; if (g_st[k] !== 2'd0) $display("FAIL rst_state%0d got %0d want 0", k, g_st[k]); else n_pass++;
         n_chk++; if (g_sc[k] !== 0 || g_fc[k] !== 0) $display("FAIL rst_cnt%0d got %0d/%0d want 0/0", k, g_sc[k], g_fc[k]); else n_pass++;
      end
      advance();
   endtask

   task automatic test_load_use();
      do_reset();
      set_load_use(5'd5, 1'b1);
      settle();
      n_chk++; if (g_ctrl[1] !== C_STALL) $display("FAIL lu_ctrl1 got %b want %b", g_ctrl[1], C_STALL); else n_pass++;
      n_chk++; if (g_ctrl[0] !== C_STALL) $display("FAIL lu_ctrl0 got %b want %b", g_ctrl[0], C_STALL); else n_pass++;
      advance();
      clear_inputs();
      settle();
      n_chk++; if (g_ctrl[1] !== C_IDLE || g_st[1] !== 2'd0) $display("FAIL lu_after1 got %b/%0d want %b/0", g_ctrl[1], g_st[1], C_IDLE); else n_pass++;
      n_chk++; if (g_sc[1] !== 1) $display("FAIL lu_scnt1 got %0d want 1", g_sc[1]); else n_pass++;
      n_chk++; if (g_st[0] !== 2'd1 || g_ctrl[0] !== C_STALL) $display("FAIL lu_ldst0 got %0d/%b want 1/%b", g_st[0], g_ctrl[0], C_STALL); else n_pass++;
      advance();
      settle();
      advance();
      settle();
      n_chk++; if (g_st[0] !== 2'd0 || g_sc[0] !== 3) $display("FAIL lu_done0 got st %0d scnt %0d want 0/3", g_st[0], g_sc[0]); else n_pass++;
      advance();
      set_load_use(5'd0, 1'b1);
      id_rs1 = 5'd0;
      settle();
      n_chk++; if (g_ctrl[0] !== C_IDLE || g_ctrl[1] !== C_IDLE) $display("FAIL lu_rd0 got %b/%b want idle", g_ctrl[0], g_ctrl[1]); else n_pass++;
      advance();
      set_load_use(5'd5, 1'b0);
      settle();
      n_chk++; if (g_ctrl[0] !== C_IDLE || g_ctrl[1] !== C_IDLE) $display("FAIL lu_unused got %b/%b want idle", g_ctrl[0], g_ctrl[1]); else n_pass++;
      advance();
      clear_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      ex_branch_resolve = 1; ex_mispredict = 1;
      for (int c = 0; c < 3; c++) begin
         settle();
         n_chk++; if (g_ctrl[0] !== C_SQ) $display("FAIL fl_ctrl0 cyc %0d got %b want %b", c, g_ctrl[0], C_SQ); else n_pass++;
         n_chk++; if (g_st[0] !== ((c == 0) ? 2'd0 : 2'd2)) $display("FAIL fl_state0 cyc %0d got %0d", c, g_st[0]); else n_pass++;
         advance();
         clear_inputs();
      end
      settle();
      n_chk++; if (g_st[0] !== 2'd0 || g_ctrl[0] !== C_IDLE) $display("FAIL fl_end0 got %0d/%b want 0/%b", g_st[0], g_ctrl[0], C_IDLE); else n_pass++;
      n_chk++; if (g_fc[0] !== 3) $display("FAIL fl_fcnt0 got %0d want 3", g_fc[0]); else n_pass++;
      n_chk++; if (g_fc[1] !== 1) $display("FAIL fl_fcnt1 got %0d want 1", g_fc[1]); else n_pass++;
      advance();
   endtask

   task automatic test_busy_in_stall();
      logic [4:0] want;
      do_reset();
      set_load_use(5'd7, 1'b1);
      id_rs1 = 5'd7;
      for (int c = 0; c < 6; c++) begin
         settle();
         want = (c == 5) ? C_IDLE : ((c == 1 || c == 2) ? C_BUSY : C_STALL);
         n_chk++; if (g_ctrl[0] !== want) $display("FAIL bs_ctrl0 cyc %0d got %b want %b", c, g_ctrl[0], want); else n_pass++;
         advance();
         clear_inputs();
         mem_busy = (c == 0 || c == 1);
      end
      n_chk++; if (g_sc[0] !== 5) $display("FAIL bs_scnt0 got %0d want 5", g_sc[0]); else n_pass++;
      n_chk++; if (g_sc[1] !== 3) $display("FAIL bs_scnt1 got %0d want 3", g_sc[1]); else n_pass++;
   endtask

   task automatic test_mp_in_stall();
      do_reset();
      set_load_use(5'd9, 1'b1);
      id_rs1 = 5'd9;
      settle();
      advance();
      clear_inputs();
      ex_branch_resolve = 1; ex_mispredict = 1;
      settle();
      n_chk++; if (g_st[0] !== 2'd1 || g_ctrl[0] !== C_SQ) $display("FAIL mps_ctrl0 got %0d/%b want 1/%b", g_st[0], g_ctrl[0], C_SQ); else n_pass++;
      advance();
      clear_inputs();
      settle();
      n_chk++; if (g_st[0] !== 2'd2) $display("FAIL mps_state0 got %0d want 2", g_st[0]); else n_pass++;
      advance();
      settle();
      advance();
      do_reset();
      mem_busy = 1;
      for (int c = 0; c < 20; c++) begin
         settle();
         advance();
      end
      mem_busy = 0;
      settle();
      n_chk++; if (g_sc[0] !== 15) $display("FAIL sat_scnt0 got %0d want 15", g_sc[0]); else n_pass++;
      n_chk++; if (g_sc[1] !== 20) $display("FAIL sat_scnt1 got %0d want 20", g_sc[1]); else n_pass++;
      advance();
   endtask

   task automatic test_reset_mid_flush();
      do_reset();
      ex_branch_resolve = 1; ex_mispredict = 1;
      settle();
      advance();
      clear_inputs();
      settle();
      advance();
      reset = 1;
      settle();
      n_chk++; if (g_st[0] !== 2'd2 || g_ctrl[0] !== C_IDLE) $display("FAIL rmf_during got %0d/%b want 2/%b", g_st[0], g_ctrl[0], C_IDLE); else n_pass++;
      advance();
      reset = 0;
      settle();
      n_chk++; if (g_st[0] !== 2'd0 || g_fc[0] !== 0 || g_ctrl[0] !== C_IDLE) $display("FAIL rmf_after got st %0d fcnt %0d ctrl %b want 0/0/%b", g_st[0], g_fc[0], g_ctrl[0], C_IDLE); else n_pass++;
      advance();
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         id_valid = ($urandom_range(0, 3) != 0);
         id_rs1 = 5'($urandom_range(0, 3));
         id_rs2 = 5'($urandom_range(0, 3));
         id_rs1_used = ($urandom_range(0, 3) != 0);
         id_rs2_used = ($urandom_range(0, 1) != 0);
         ex_valid = ($urandom_range(0, 3) != 0);
         ex_rd = 5'($urandom_range(0, 3));
         ex_rd_memory = ($urandom_range(0, 1) != 0);
         ex_save_to_reg = ($urandom_range(0, 3) != 0);
         ex_branch_resolve = ($urandom_range(0, 5) == 0);
         ex_mispredict = ($urandom_range(0, 1) != 0);
         mem_busy = ($urandom_range(0, 7) == 0);
         settle();
         for (int k = 0; k < 2; k++) begin
            n_chk++; if (g_ctrl[k] !== e_ctrl[k]) $display("FAIL rnd_ctrl%0d cyc %0d got %b want %b", k, c, g_ctrl[k], e_ctrl[k]); else n_pass++;
            n_chk++; if (g_st[k] !== e_st[k]) $display("FAIL rnd_state%0d cyc %0d got %0d want %0d", k, c, g_st[k], e_st[k]); else n_pass++;
            n_chk++; if (g_sc[k] !== m_sc[k]) $display("FAIL rnd_scnt%0d cyc %0d got %0d want %0d", k, c, g_sc[k], m_sc[k]); else n_pass++;
            n_chk++; if (g_fc[k] !== m_fc[k]) $display("FAIL rnd_fcnt%0d cyc %0d got %0d want %0d", k, c, g_fc[k], m_fc[k]); else n_pass++;
         end
         advance();
      end
      reset = 0;
      clear_inputs();
   endtask

   initial begin
      reset = 1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_flush();
      test_busy_in_stall();
      test_mp_in_stall();
      test_reset_mid_flush();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
